// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared types and glyph constants for the two-digit display
// Purpose: scan FSM state encoding, blank/dash segment patterns and the
//          0-9 glyph table (active-low {g,f,e,d,c,b,a}).
// Ports: none (package).
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    S_ONES,
    S_GAP1,
    S_TENS,
    S_GAP0
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] DIGIT_GLYPH [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/bcd_2digit_7seg_scan_if.sv
// rtl/bcd_2digit_7seg_scan_if.sv - digit load and display pin bundle
// Purpose: groups the BCD load side and the 7-segment pin side of the scanner.
// Ports (signals):
//   load       1  capture strobe for tens_in/ones_in
//   tens_in    4  tens BCD digit
//   ones_in    4  ones BCD digit
//   blank_lz   1  leading-zero blanking enable
//   an         2  anode enables, active-low (an[0]=ones, an[1]=tens)
//   seg        7  segments {g,f,e,d,c,b,a}, active-low
//   frame_tick 1  pulse on the first cycle of each ones dwell
interface bcd_2digit_7seg_scan_if;
  logic       load;
  logic [3:0] tens_in;
  logic [3:0] ones_in;
  logic       blank_lz;
  logic [1:0] an;
  logic [6:0] seg;
  logic       frame_tick;

  modport master (
    output load, tens_in, ones_in, blank_lz,
    input  an, seg, frame_tick
  );

  modport slave (
    input  load, tens_in, ones_in, blank_lz,
    output an, seg, frame_tick
  );
endinterface

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to active-low 7-segment decoder
// Purpose: maps one BCD digit to its glyph; codes 10-15 show a dash.
// Ports:
//   bcd_i  4  BCD digit
//   seg_o  7  active-low segments {g,f,e,d,c,b,a}
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i <= 4'd9) seg_o = DIGIT_GLYPH[bcd_i];
  end

endmodule

// File: rtl/bcd_2digit_7seg_scan.sv
// rtl/bcd_2digit_7seg_scan.sv - two-digit common-anode 7-segment scanner
// Purpose: shadows a tens/ones BCD pair on load and time-multiplexes it onto
//          the display as ones dwell, gap, tens dwell, gap, with optional
//          leading-zero blanking. All pin outputs are registered.
// Ports:
//   clk  1  system clock
//   rst  1  synchronous active-high reset
//   bus     slave modport of bcd_2digit_7seg_scan_if (load side + pins)
module bcd_2digit_7seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int GAP   = 4
) (
  input logic                  clk,
  input logic                  rst,
  bcd_2digit_7seg_scan_if.slave bus
);

  localparam int MAXN = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(MAXN + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q;
  logic [3:0]    tens_q, ones_q;
  logic [3:0]    digit_q, digit_d;
  logic          enter_d;
  logic [6:0]    glyph;
  logic [1:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick_q, tick_d;

  // start_q marks the first edge out of reset: it enters the ones dwell at
  // count 0 rather than advancing, so the first dwell is a full DWELL long.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    if (start_q) begin
      state_d = S_ONES;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_ONES: if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = (GAP > 0) ? S_GAP1 : S_TENS;
        end
        S_GAP1: if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_TENS;
        end
        S_TENS: if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = (GAP > 0) ? S_GAP0 : S_ONES;
        end
        S_GAP0: if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_ONES;
        end
        default: begin
          cnt_d   = '0;
          state_d = S_ONES;
        end
      endcase
    end

    // The dwell digit is frozen from the pre-edge shadow on entry, so a load
    // on the same edge only shows up in the next dwell of that digit.
    enter_d = start_q || (state_d != state_q);
    digit_d = digit_q;
    if (enter_d && state_d == S_ONES) digit_d = ones_q;
    if (enter_d && state_d == S_TENS) digit_d = tens_q;
  end

  bcd_to_7seg u_dec (
    .bcd_i (digit_d),
    .seg_o (glyph)
  );

  always_comb begin
    an_d   = 2'b11;
    seg_d  = SEG_OFF;
    tick_d = enter_d && (state_d == S_ONES);
    if (state_d == S_ONES) begin
      an_d  = 2'b10;
      seg_d = glyph;
    end else if (state_d == S_TENS && !(bus.blank_lz && digit_d == 4'd0)) begin
      an_d  = 2'b01;
      seg_d = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ONES;
      cnt_q   <= '0;
      start_q <= 1'b1;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      digit_q <= 4'd0;
      an_q    <= 2'b11;
      seg_q   <= SEG_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= 1'b0;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
      if (bus.load) begin
        tens_q <= bus.tens_in;
        ones_q <= bus.ones_in;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_2digit_7seg_scan.sv
// tb/tb_bcd_2digit_7seg_scan.sv - scoreboard bench for the two-digit scanner
module tb_bcd_2digit_7seg_scan;

  localparam int DWELL = 4;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       ft;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_2digit_7seg_scan_if bus_a ();
  bcd_2digit_7seg_scan_if bus_b ();

  bcd_2digit_7seg_scan #(.DWELL(DWELL), .GAP(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  bcd_2digit_7seg_scan #(.DWELL(DWELL), .GAP(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: edge index since reset release per build,
  // shared shadow pair, and per-build digit latched for the current dwell.
  int         t_idx [2];
  logic [3:0] sh_tens, sh_ones;
  logic [3:0] lat_o [2];
  logic [3:0] lat_t [2];
  logic       blz_cur;

  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (v > 4'd9) ? 7'b0111111 : tbl[v];
  endfunction

  task automatic cycle(input logic r, input logic ld, input logic [3:0] tv,
                       input logic [3:0] ov, input logic blz);
    exp_t e;
    int   gap, per, p;
    @(negedge clk);
    rst = r;
    bus_a.load = ld; bus_a.tens_in = tv; bus_a.ones_in = ov; bus_a.blank_lz = blz;
    bus_b.load = ld; bus_b.tens_in = tv; bus_b.ones_in = ov; bus_b.blank_lz = blz;
    for (int k = 0; k < 2; k++) begin
      gap = (k == 0) ? 2 : 0;
      per = 2 * (DWELL + gap);
      if (r) begin
        e = '{2'b11, 7'h7F, 1'b0};
        t_idx[k] = 0;
      end else begin
        p = t_idx[k] % per;
        if (p == 0) lat_o[k] = sh_ones;
        if (p == DWELL + gap) lat_t[k] = sh_tens;
        if (p < DWELL)
          e = '{2'b10, glyph_of(lat_o[k]), (p == 0)};
        else if (p >= DWELL + gap && p < 2 * DWELL + gap)
          e = (blz && lat_t[k] == 4'd0) ? '{2'b11, 7'h7F, 1'b0}
                                         : '{2'b01, glyph_of(lat_t[k]), 1'b0};
        else
          e = '{2'b11, 7'h7F, 1'b0};
        t_idx[k]++;
      end
      if (k == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
    if (r) begin
      sh_tens = 4'd0;
      sh_ones = 4'd0;
    end else if (ld) begin
      sh_tens = tv;
      sh_ones = ov;
    end
  endtask

  task automatic cmp(input string name, input int v_act, input int v_exp);
    checks++;
    if (v_act !== v_exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, v_act, v_exp);
    end
  endtask

  // Monitor: the display presents a new output every edge; compare just
  // after it against whatever the driver queued for that edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      cmp("gap2_an",  int'(bus_a.an),         int'(e.an));
      cmp("gap2_seg", int'(bus_a.seg),        int'(e.seg));
      cmp("gap2_ft",  int'(bus_a.frame_tick), int'(e.ft));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      cmp("gap0_an",  int'(bus_b.an),         int'(e.an));
      cmp("gap0_seg", int'(bus_b.seg),        int'(e.seg));
      cmp("gap0_ft",  int'(bus_b.frame_tick), int'(e.ft));
    end
  end

  initial begin
    logic       r, ld, blz;
    logic [3:0] tv, ov;
    bus_a.load = 1'b0; bus_a.tens_in = 4'd0; bus_a.ones_in = 4'd0; bus_a.blank_lz = 1'b0;
    bus_b.load = 1'b0; bus_b.tens_in = 4'd0; bus_b.ones_in = 4'd0; bus_b.blank_lz = 1'b0;
    sh_tens = 4'd0;
    sh_ones = 4'd0;
    blz_cur = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t_idx[k] = 0;
      lat_o[k] = 4'd0;
      lat_t[k] = 4'd0;
    end

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

    // Directed sweep of every code on both digits, with and without blanking.
    for (int d = 0; d < 16; d++) begin
      cycle(1'b0, 1'b1, 4'(d), 4'(15 - d), d[0]);
      for (int i = 0; i < 23; i++) cycle(1'b0, 1'b0, 4'd0, 4'd0, d[0]);
    end

    // Leading zero with tens=0, ones=5 under both blanking settings.
    cycle(1'b0, 1'b1, 4'd0, 4'd5, 1'b1);
    for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

    // Randomised loads, blanking toggles and occasional mid-frame resets.
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      ld = ($urandom_range(0, 4) == 0);
      tv = 4'($urandom_range(0, 15));
      ov = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) blz_cur = ~blz_cur;
      blz = blz_cur;
      cycle(r, ld, tv, ov, blz);
    end

    @(posedge clk);
    #2;
    cmp("queue_a_drained", q_a.size(), 0);
    cmp("queue_b_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
